// File: rtl/mem_burst_master.sv
// Burst initiator for the 32-word register memory port.
// Takes write or read burst commands from a host and walks sequential memory
// addresses (wrapping at 2**AW). Write data streams in on a valid/ready pair.
// Read data streams out through a registered, backpressured valid/ready pair.
module mem_burst_master #(
  parameter int n  = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [5:0]    cmd_len,
  input  logic [n-1:0]  wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [n-1:0]  rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address,
  output logic          mem_readWrite,
  output logic [n-1:0]  mem_in,
  input  logic [n-1:0]  mem_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [5:0]    cnt_q;
  logic          rd_slot;
  logic          rd_load;

  // The output register is free when it is empty or is being consumed this cycle.
  assign rd_slot = !rd_valid || rd_ready;
  assign rd_load = rd_slot && (cnt_q != 6'd0);

  // Status and handshake outputs decode directly from the registered state.
  // A write strobe is only ever raised inside WRITE, so an async reset
  // kills it at once.
  assign cmd_ready     = (state == IDLE);
  assign busy          = (state == WRITE) || (state == READ);
  assign done          = (state == DONE);
  assign wr_ready      = (state == WRITE);
  assign mem_address   = addr_q;
  assign mem_readWrite = (state == WRITE) && wr_valid;
  assign mem_in        = (state == WRITE) ? wr_data : '0;

  // Burst FSM: command capture, address/count walk, and the read output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_valid <= 1'b0;
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            if (cmd_len == 6'd0)  state <= DONE;
            else if (cmd_write)   state <= WRITE;
            else                  state <= READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (cnt_q == 6'd1) state <= DONE;
          end
        end
        READ: begin
          if (rd_load) begin
            rd_data  <= mem_out;
            rd_valid <= 1'b1;
            addr_q   <= addr_q + 1'b1;
            cnt_q    <= cnt_q - 1'b1;
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
          end
          // Leave only once the final word has been handed over.
          if ((cnt_q == 6'd0) && rd_slot) state <= DONE;
        end
        DONE: begin
          rd_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a 32x8 behavioural memory attached.
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [4:0] cmd_addr;
  logic [5:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       busy, done;
  logic [4:0] mem_address;
  logic       mem_readWrite;
  logic [7:0] mem_in, mem_out;

  logic [7:0] mem [32];
  logic       mem_clr;

  int passed = 0;
  int total  = 0;

  mem_burst_master #(.n(8), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_readWrite(mem_readWrite),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Register memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (mem_readWrite) begin
      mem[mem_address] <= mem_in;
    end
  end
  assign mem_out = mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] da [4];
    logic [7:0] db [4];
    logic [7:0] dc [4];
    logic       pat [7];
    logic       prev_stall;
    logic [7:0] prev_data;
    int         k;
    logic       got_done;

    da  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    db  = '{8'h11, 8'h22, 8'h33, 8'h44};
    dc  = '{8'h55, 8'h66, 8'h77, 8'h88};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b0; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_mem_rw", mem_readWrite, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_rd_data", rd_data, 0);
    mem_clr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Write addr=3 len=4, wr_valid held high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd3; cmd_len = 6'd4;
    wr_valid = 1'b1; wr_data = da[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_data = da[i];
      chk("wr_ready", wr_ready, 1);
      chk("wr_addr", mem_address, 3 + i);
      chk("wr_strobe", mem_readWrite, 1);
      chk("wr_busy", busy, 1);
      chk("wr_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    chk("wr_done", done, 1);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    chk("wr_done_no_strobe", mem_readWrite, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse_end", done, 0);
    chk("wr_idle_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) chk("wr_mem", mem[3 + i], da[i]);

    // Read addr=3 len=4, rd_ready held high
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3; cmd_len = 6'd4;
    rd_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_first_empty", rd_valid, 0);
    chk("rd_busy", busy, 1);
    chk("rd_no_strobe", mem_readWrite, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, da[i]);
    end
    @(negedge clk);
    chk("rd_done", done, 1);
    chk("rd_done_valid", rd_valid, 0);
    @(negedge clk);
    chk("rd_idle", cmd_ready, 1);

    // Write across the wrap point: 30,31,0,1
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd30; cmd_len = 6'd4;
    wr_valid = 1'b1; wr_data = db[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_data = db[i];
      chk("wrap_addr", mem_address, (30 + i) % 32);
    end
    @(negedge clk);
    chk("wrap_done", done, 1);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wrap_mem30", mem[30], 8'h11);
    chk("wrap_mem31", mem[31], 8'h22);
    chk("wrap_mem0", mem[0], 8'h33);
    chk("wrap_mem1", mem[1], 8'h44);

    // Read with stalls; each consumed word must come in order and stay put while held
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd30; cmd_len = 6'd4;
    rd_ready = 1'b1;
    prev_stall = 1'b0; prev_data = '0; k = 0; got_done = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) begin
        got_done = 1'b1;
        chk("stall_done_valid", rd_valid, 0);
        break;
      end
      rd_ready = (cyc < 7) ? pat[cyc] : 1'b1;
      if (prev_stall) begin
        chk("stall_hold_valid", rd_valid, 1);
        chk("stall_hold_data", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        if (k < 4) chk("stall_word", rd_data, db[k]);
        k++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end
    chk("stall_word_count", k, 4);
    chk("stall_done_seen", got_done, 1);
    rd_ready = 1'b0;
    @(negedge clk);

    // Zero-length command: done one cycle after accept, never a write strobe
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd7; cmd_len = 6'd0;
    wr_valid = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_no_strobe", mem_readWrite, 0);
    chk("len0_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("len0_done_end", done, 0);
    chk("len0_idle", cmd_ready, 1);
    chk("len0_mem7", mem[7], 8'h00);

    // Reset after two of four writes
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd10; cmd_len = 6'd4;
    wr_valid = 1'b1; wr_data = dc[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_data = dc[i];
    end
    chk("mid_strobe_before", mem_readWrite, 1);
    reset = 1'b0;
    #1;
    chk("mid_strobe_drop", mem_readWrite, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", done, 0);
    end
    chk("mid_mem10", mem[10], 8'h55);
    chk("mid_mem11", mem[11], 8'h66);
    chk("mid_mem12", mem[12], 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
